// File: rtl/c499_seq_pkg.sv
// c499_seq_pkg: shared widths, FSM state encoding and MISR polynomial
// for the c499 vector sequencer.
package c499_seq_pkg;

    localparam int C499_VEC_WIDTH  = 41;
    localparam int C499_RESP_WIDTH = 32;
    localparam int C499_VEC_DEPTH  = 16;

    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } seq_state_e;

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
        return {sig[30:0], ^(sig & MISR_TAPS)} ^ din;
    endfunction

endpackage

// File: rtl/c499_misr.sv
// c499_misr: 32-bit multiple-input signature register compacting the
// captured c499 responses.
module c499_misr
    import c499_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);

    logic [31:0] sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else if (clr) sig_q <= '0;
        else if (en) sig_q <= misr_step(sig_q, din);
    end

    assign sig = sig_q;

endmodule

// File: rtl/c499_vector_sequencer.sv
// c499_vector_sequencer: replays stored stimulus vectors into a c499 block,
// captures each settled response and compacts the run into a MISR signature.
module c499_vector_sequencer
    import c499_seq_pkg::*;
#(
    parameter int VEC_WIDTH     = C499_VEC_WIDTH,
    parameter int RESP_WIDTH    = C499_RESP_WIDTH,
    parameter int VEC_DEPTH     = C499_VEC_DEPTH,
    parameter int SETTLE_CYCLES = 1,
    localparam int AW           = $clog2(VEC_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [VEC_WIDTH-1:0]  wr_data,
    input  logic                  start,
    input  logic [AW:0]           num_vec,
    input  logic [15:0]           loop_cnt,
    output logic [VEC_WIDTH-1:0]  dut_in,
    input  logic [RESP_WIDTH-1:0] dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  resp_valid,
    output logic [RESP_WIDTH-1:0] resp_data,
    output logic [AW-1:0]         resp_idx,
    output logic [31:0]           signature
);

    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_e            state_q;
    logic [VEC_WIDTH-1:0]  mem [VEC_DEPTH];
    logic [AW:0]           nv_q;
    logic [AW:0]           nv_clamped;
    logic [15:0]           loops_q;
    logic [15:0]           pass_q;
    logic [AW-1:0]         idx_q;
    logic [CW-1:0]         cnt_q;
    logic [VEC_WIDTH-1:0]  dut_in_q;
    logic [RESP_WIDTH-1:0] resp_data_q;
    logic [AW-1:0]         resp_idx_q;
    logic                  resp_valid_q;
    logic                  done_q;
    logic                  accept;
    logic                  capture_en;
    logic                  more_vec;
    logic                  more_pass;

    assign accept     = state_q == S_IDLE && start;
    assign capture_en = state_q == S_SETTLE && cnt_q == '0;
    assign nv_clamped = num_vec > (AW+1)'(VEC_DEPTH) ? (AW+1)'(VEC_DEPTH) : num_vec;
    assign more_vec   = {1'b0, idx_q} + (AW+1)'(1) < nv_q;
    assign more_pass  = {1'b0, pass_q} + 17'd1 < {1'b0, loops_q};

    // Memory is frozen outside IDLE so a run always replays a stable vector set.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == S_IDLE && {1'b0, wr_addr} < (AW+1)'(VEC_DEPTH))
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            nv_q         <= '0;
            loops_q      <= '0;
            pass_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            dut_in_q     <= '0;
            resp_data_q  <= '0;
            resp_idx_q   <= '0;
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    nv_q    <= nv_clamped;
                    loops_q <= loop_cnt == '0 ? 16'd1 : loop_cnt;
                    pass_q  <= '0;
                    idx_q   <= '0;
                    state_q <= nv_clamped == '0 ? S_DONE : S_APPLY;
                    done_q  <= nv_clamped == '0;
                end
                S_APPLY: begin
                    dut_in_q <= mem[idx_q];
                    cnt_q    <= CW'(SETTLE_CYCLES - 1);
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: if (cnt_q == '0) begin
                    state_q      <= S_CAPTURE;
                    resp_data_q  <= dut_out;
                    resp_idx_q   <= idx_q;
                    resp_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
                S_CAPTURE: if (more_vec) begin
                    idx_q   <= idx_q + AW'(1);
                    state_q <= S_APPLY;
                end else if (more_pass) begin
                    idx_q   <= '0;
                    pass_q  <= pass_q + 16'd1;
                    state_q <= S_APPLY;
                end else begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    c499_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (capture_en),
        .din   (32'(dut_out)),
        .sig   (signature)
    );

    assign busy       = state_q != S_IDLE;
    assign done       = done_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_idx   = resp_idx_q;
    assign dut_in     = dut_in_q;

endmodule

// File: tb/tb_c499_vector_sequencer.sv
// tb_c499_vector_sequencer: directed bench driving two sequencers (settle 1 and 4)
// against a combinational c499 stand-in and a reference MISR.
module tb_c499_vector_sequencer;

    localparam int VW = 41;
    localparam int RW = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en_a, wr_en_b, start_a, start_b;
    logic [AW-1:0] wr_addr;
    logic [VW-1:0] wr_data;
    logic [AW:0]   num_vec;
    logic [15:0]   loop_cnt;

    logic [VW-1:0] dut_in_a, dut_in_b;
    logic [RW-1:0] dut_out_a, dut_out_b, rd_a, rd_b;
    logic [AW-1:0] ri_a, ri_b;
    logic          busy_a, busy_b, done_a, done_b, rv_a, rv_b;
    logic [31:0]   sig_a, sig_b;

    logic [VW-1:0] vec [D];
    logic [31:0]   s_full, s_tmp;
    int            checks = 0;
    int            failures = 0;

    function automatic logic [31:0] c499_model(input logic [40:0] v);
        return v[40:9] ^ {v[8:0], v[8:0], v[8:0], v[8:4]};
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] r);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ r;
    endfunction

    assign dut_out_a = c499_model(dut_in_a);
    assign dut_out_b = c499_model(dut_in_b);

    c499_vector_sequencer u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_a), .num_vec(num_vec), .loop_cnt(loop_cnt), .dut_in(dut_in_a),
        .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .resp_valid(rv_a),
        .resp_data(rd_a), .resp_idx(ri_a), .signature(sig_a)
    );

    c499_vector_sequencer #(.SETTLE_CYCLES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_b), .num_vec(num_vec), .loop_cnt(loop_cnt), .dut_in(dut_in_b),
        .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .resp_valid(rv_b),
        .resp_data(rd_b), .resp_idx(ri_b), .signature(sig_b)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // Starts a run and checks it cycle by cycle; inj >= 0 injects start+write mid-run.
    task automatic run_check(input string tag, input int nv, input int lc, input bit slow,
                             input int inj, output logic [31:0] sig_out);
        int nve, passes, per, ca, idx;
        logic [31:0] e, r;
        nve    = nv > D ? D : nv;
        passes = lc == 0 ? 1 : lc;
        per    = slow ? 6 : 3;
        e      = '0;
        ca     = 0;
        num_vec  = (AW+1)'(nv);
        loop_cnt = 16'(lc);
        if (slow) start_b = 1'b1; else start_a = 1'b1;
        step();
        chk({tag, ".busy"}, slow ? busy_b : busy_a, 1);
        chk({tag, ".sig0"}, slow ? sig_b : sig_a, 0);
        if (nve == 0) begin
            chk({tag, ".done"}, slow ? done_b : done_a, 1);
            chk({tag, ".rv"}, slow ? rv_b : rv_a, 0);
            step();
            chk({tag, ".done_end"}, slow ? done_b : done_a, 0);
            chk({tag, ".idle"}, slow ? busy_b : busy_a, 0);
            chk({tag, ".sig_end"}, slow ? sig_b : sig_a, 0);
            sig_out = '0;
            return;
        end
        for (int v = 0; v < nve * passes; v++) begin
            idx = v % nve;
            r   = c499_model(vec[idx]);
            for (int c = 0; c < per; c++) begin
                if (c > 0) begin
                    step();
                    chk({tag, ".dut_in"}, slow ? dut_in_b : dut_in_a, vec[idx]);
                end
                if (c == per - 1) begin
                    e = misr_ref(e, r);
                    chk({tag, ".rv"}, slow ? rv_b : rv_a, 1);
                    chk({tag, ".ridx"}, slow ? ri_b : ri_a, idx);
                    chk({tag, ".rdata"}, slow ? rd_b : rd_a, r);
                    chk({tag, ".sig"}, slow ? sig_b : sig_a, e);
                end else begin
                    chk({tag, ".rv_low"}, slow ? rv_b : rv_a, 0);
                    chk({tag, ".done_low"}, slow ? done_b : done_a, 0);
                end
                if (ca == inj) begin
                    start_a = 1'b1;
                    wr_en_a = 1'b1;
                    wr_addr = 4'd2;
                    wr_data = '0;
                end
                ca++;
            end
            step();
        end
        chk({tag, ".done"}, slow ? done_b : done_a, 1);
        chk({tag, ".rv_at_done"}, slow ? rv_b : rv_a, 0);
        chk({tag, ".sig_done"}, slow ? sig_b : sig_a, e);
        step();
        chk({tag, ".done_end"}, slow ? done_b : done_a, 0);
        chk({tag, ".idle"}, slow ? busy_b : busy_a, 0);
        chk({tag, ".sig_hold"}, slow ? sig_b : sig_a, e);
        sig_out = e;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        num_vec = '0;
        loop_cnt = '0;
        for (int i = 0; i < D; i++)
            vec[i] = (41'h155_5555_5555 >> i) ^ (41'(i) * 41'h0_0123_4567) ^ 41'h0AB_CDEF_0123;
        step();
        step();
        chk("reset.busy", busy_a, 0);
        chk("reset.done", done_a, 0);
        chk("reset.rv", rv_a, 0);
        chk("reset.dut_in", dut_in_a, 0);
        chk("reset.rdata", rd_a, 0);
        chk("reset.ridx", ri_a, 0);
        chk("reset.sig", sig_a, 0);
        chk("reset.busy_b", busy_b, 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < D; i++) begin
            wr_en_a = 1'b1;
            wr_en_b = 1'b1;
            wr_addr = AW'(i);
            wr_data = vec[i];
            step();
        end

        run_check("full", 16, 1, 1'b0, -1, s_full);
        step();
        step();
        chk("hold.dut_in", dut_in_a, vec[15]);
        chk("hold.rdata", rd_a, c499_model(vec[15]));
        chk("hold.sig", sig_a, s_full);

        run_check("zero", 0, 5, 1'b0, -1, s_tmp);
        run_check("loop", 2, 3, 1'b0, -1, s_tmp);

        num_vec  = 5'd16;
        loop_cnt = 16'd1;
        start_a  = 1'b1;
        step();
        repeat (14) step();
        chk("rst.pre_rv", rv_a, 1);
        chk("rst.pre_ridx", ri_a, 4);
        rst_n = 1'b0;
        #1;
        chk("rst.dut_in", dut_in_a, 0);
        chk("rst.rdata", rd_a, 0);
        chk("rst.ridx", ri_a, 0);
        chk("rst.rv", rv_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.done", done_a, 0);
        chk("rst.sig", sig_a, 0);
        step();
        rst_n = 1'b1;
        step();
        run_check("rerun", 16, 1, 1'b0, -1, s_tmp);
        chk("rerun.sig_vs_first", sig_a, s_full);

        run_check("inject", 4, 1, 1'b0, 1, s_tmp);
        step();
        chk("inject.no_restart", busy_a, 0);
        run_check("readback", 4, 1, 1'b0, -1, s_tmp);

        run_check("clamp", 20, 0, 1'b0, -1, s_tmp);
        chk("clamp.sig_vs_full", sig_a, s_full);

        run_check("slow", 3, 1, 1'b1, -1, s_tmp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
